// File: rtl/apple2_disk_pkg.sv
// Shared Disk II track constants, write-back states and LBA helper.
// Used by both the NIB track loader and the track write-back engine.
package apple2_disk_pkg;

  localparam int SECS_PER_TRACK = 13;
  localparam int TRACK_BYTES    = 6656;
  localparam int TRK_W          = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK_HI,
    ACK_LO
  } wb_state_t;

  // Zero-extended so track 63 sector 12 (831) never wraps.
  function automatic logic [31:0] trk_lba(
    input logic [TRK_W-1:0] t,
    input logic [3:0]       s
  );
    return 32'(t) * 32'(SECS_PER_TRACK) + 32'(s);
  endfunction

endpackage

// File: rtl/disk_track_writeback.sv
// Saves a modified NIB track back to the mounted image via hps_io.
// Blocks the CPU and the track loader until the save completes.
module disk_track_writeback
  import apple2_disk_pkg::*;
#(
  parameter int SECS  = SECS_PER_TRACK,
  parameter int TRK_W = 6,
  parameter int LBA_W = 32
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [TRK_W-1:0] track,
  input  logic             trk_we,
  input  logic             flush,
  input  logic             img_mounted,
  input  logic             img_present,
  input  logic             img_readonly,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_wr,
  input  logic             sd_ack,
  input  logic [8:0]       sd_buff_addr,
  output logic [7:0]       sd_buff_din,
  output logic [12:0]      tr_addr,
  input  logic [7:0]       tr_dout,
  output logic             busy,
  output logic             dirty
);

  wb_state_t        state_q, state_d;
  logic [3:0]       sec_q, sec_d;
  logic [TRK_W-1:0] cur_q, cur_d;
  logic [TRK_W-1:0] wb_q, wb_d;
  logic             dirty_q, dirty_d;
  logic             abort_q, abort_d;
  logic             wr_q, wr_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             old_ack;

  logic ack_rise, ack_fall;
  logic trig, start, clr, wr_ok;

  assign ack_rise = sd_ack & ~old_ack;
  assign ack_fall = ~sd_ack & old_ack;
  assign wr_ok    = img_present & ~img_readonly;
  assign trig     = (track != cur_q) | flush;
  assign start    = trig & dirty_q & ~img_mounted;

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    cur_d   = cur_q;
    wb_d    = wb_q;
    abort_d = abort_q;
    wr_d    = wr_q;
    lba_d   = lba_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wb_d    = cur_q;
          sec_d   = 4'd0;
          state_d = REQ;
        end else begin
          cur_d = track;
        end
      end
      REQ: begin
        lba_d   = LBA_W'(trk_lba(wb_q, sec_q));
        wr_d    = 1'b1;
        state_d = ACK_HI;
      end
      ACK_HI: begin
        if (ack_rise) begin
          wr_d    = 1'b0;
          state_d = ACK_LO;
        end
      end
      ACK_LO: begin
        if (ack_fall) begin
          if (abort_q || sec_q == 4'(SECS - 1)) begin
            clr     = 1'b1;
            cur_d   = track;
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            sec_d   = sec_q + 4'd1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A remount mid-save lets the sector in flight finish, then drops the rest.
    if (img_mounted && state_q != IDLE && state_d != IDLE)
      abort_d = 1'b1;
    if (!wr_ok)
      dirty_d = 1'b0;
    else if (trk_we)
      dirty_d = 1'b1;
    else if (clr || (img_mounted && state_q == IDLE))
      dirty_d = 1'b0;
    else
      dirty_d = dirty_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q   <= '0;
      cur_q   <= '0;
      wb_q    <= '0;
      dirty_q <= 1'b0;
      abort_q <= 1'b0;
      wr_q    <= 1'b0;
      lba_q   <= '0;
      old_ack <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      cur_q   <= cur_d;
      wb_q    <= wb_d;
      dirty_q <= dirty_d;
      abort_q <= abort_d;
      wr_q    <= wr_d;
      lba_q   <= lba_d;
      old_ack <= sd_ack;
    end
  end

  assign sd_lba      = lba_q;
  assign sd_wr       = wr_q;
  assign dirty       = dirty_q;
  assign busy        = (state_q != IDLE) | start;
  assign tr_addr     = {sec_q, sd_buff_addr};
  assign sd_buff_din = tr_dout;

endmodule

// File: tb/tb_disk_track_writeback.sv
// Directed scenarios with randomized timing/data for the track write-back.
// Expected LBAs and dirty state come from a small model in this bench.
module tb_disk_track_writeback;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        trk_we, flush, img_mounted, img_present, img_readonly;
  logic [31:0] sd_lba;
  logic        sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_din;
  logic [12:0] tr_addr;
  logic [7:0]  tr_dout;
  logic        busy, dirty;

  logic [7:0]  mem [8192];
  int tests = 0;
  int fails = 0;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) tr_dout <= mem[tr_addr];

  disk_track_writeback dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .track        (track),
    .trk_we       (trk_we),
    .flush        (flush),
    .img_mounted  (img_mounted),
    .img_present  (img_present),
    .img_readonly (img_readonly),
    .sd_lba       (sd_lba),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_din  (sd_buff_din),
    .tr_addr      (tr_addr),
    .tr_dout      (tr_dout),
    .busy         (busy),
    .dirty        (dirty)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_we(input int n);
    for (int i = 0; i < n; i++) begin
      trk_we = 1'b1;
      tick();
      trk_we = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int wr = 0;
    int bz = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sd_wr) wr++;
      if (busy) bz++;
    end
    chk({tag, "_no_wr"}, wr, 0);
    chk({tag, "_no_busy"}, bz, 0);
  endtask

  // hps_io side of one sector: wait for request, check it, ack it.
  task automatic serve(input int exp_lba, input int exp_sec,
                       input bit mount_mid, input bit we_at_end,
                       output bit ok);
    logic [8:0]  a;
    logic [12:0] ea;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sd_wr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wr_seen", 32'(ok), 1);
    if (!ok) return;
    chk("lba", sd_lba, exp_lba);
    chk("busy_in_xfer", 32'(busy), 1);
    if (mount_mid) begin
      img_mounted = 1'b1;
      tick();
      img_mounted = 1'b0;
    end
    repeat ($urandom_range(0, 3)) tick();
    chk("wr_hold", 32'(sd_wr), 1);
    sd_ack = 1'b1;
    tick();
    chk("wr_drop", 32'(sd_wr), 0);
    for (int i = 0; i < 4; i++) begin
      a = 9'($urandom);
      sd_buff_addr = a;
      ea = {4'(exp_sec), a};
      #1;
      if (i == 0) chk("tr_addr", 32'(tr_addr), 32'(ea));
      tick();
      if (i == 0) chk("buff_din", 32'(sd_buff_din), 32'(mem[ea]));
    end
    sd_ack = 1'b0;
    if (we_at_end) trk_we = 1'b1;
    tick();
    trk_we = 1'b0;
  endtask

  task automatic writeback(input int t, input bit we_last);
    bit ok;
    for (int s = 0; s < 13; s++) begin
      serve(t * 13 + s, s, 1'b0, we_last && s == 12, ok);
      if (!ok) return;
    end
  endtask

  bit ok;
  bit mdl_dirty;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    track = 6'd5;
    trk_we = 0; flush = 0; img_mounted = 0;
    img_present = 1; img_readonly = 0;
    sd_ack = 0; sd_buff_addr = 9'd3;
    tick(); tick();
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dirty", 32'(dirty), 0);
    chk("rst_tr_addr", 32'(tr_addr), 3);
    reset = 1'b0;
    tick(); tick();

    // dirty track 5, move to 6
    pulse_we($urandom_range(3, 3));
    mdl_dirty = 1'b1;
    chk("dirty_set", 32'(dirty), 32'(mdl_dirty));
    track = 6'd6;
    #1;
    chk("busy_same_cycle", 32'(busy), 1);
    tick();
    chk("busy_next", 32'(busy), 1);
    writeback(5, 1'b0);
    mdl_dirty = 1'b0;
    chk("wb5_dirty", 32'(dirty), 32'(mdl_dirty));
    chk("wb5_busy", 32'(busy), 0);
    quiet("after_wb5", 10);

    // clean track change, then dirty via flush proves cur_track followed
    track = 6'd5; tick(); track = 6'd6;
    quiet("clean_change", 15);
    pulse_we(1);
    flush = 1'b1; tick(); flush = 1'b0;
    writeback(6, 1'b0);
    chk("wb6_dirty", 32'(dirty), 0);

    // flush on track 0 dirty, then clean flush
    track = 6'd0;
    quiet("to_trk0", 5);
    pulse_we($urandom_range(1, 4));
    flush = 1'b1; tick(); flush = 1'b0;
    writeback(0, 1'b0);
    chk("wb0_dirty", 32'(dirty), 0);
    flush = 1'b1; tick(); flush = 1'b0;
    quiet("clean_flush", 15);

    // read-only image ignores writes
    img_readonly = 1'b1;
    pulse_we(3);
    chk("ro_dirty", 32'(dirty), 0);
    track = 6'd9;
    quiet("ro_change", 15);
    img_readonly = 1'b0;

    // remount during sector 4
    track = 6'd2;
    quiet("to_trk2", 3);
    pulse_we(2);
    track = 6'd3;
    for (int s = 0; s < 4; s++) serve(2 * 13 + s, s, 1'b0, 1'b0, ok);
    serve(2 * 13 + 4, 4, 1'b1, 1'b0, ok);
    chk("abort_dirty", 32'(dirty), 0);
    chk("abort_busy", 32'(busy), 0);
    quiet("abort_no_sec5", 30);

    // write on the final ack fall keeps dirty set
    pulse_we(1);
    flush = 1'b1; tick(); flush = 1'b0;
    writeback(3, 1'b1);
    chk("setwins_dirty", 32'(dirty), 1);
    chk("setwins_busy", 32'(busy), 0);
    flush = 1'b1; tick(); flush = 1'b0;
    writeback(3, 1'b0);
    chk("rewrite_dirty", 32'(dirty), 0);

    // top track: last LBA is 831
    track = 6'd63;
    quiet("to_trk63", 3);
    pulse_we(1);
    flush = 1'b1; tick(); flush = 1'b0;
    writeback(63, 1'b0);
    chk("wb63_dirty", 32'(dirty), 0);

    // reset mid-transfer discards everything
    pulse_we(1);
    track = 6'd10;
    for (int i = 0; i < 20 && !sd_wr; i++) tick();
    chk("pre_reset_wr", 32'(sd_wr), 1);
    reset = 1'b1;
    tick();
    chk("midrst_wr", 32'(sd_wr), 0);
    chk("midrst_dirty", 32'(dirty), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_lba", sd_lba, 0);
    reset = 1'b0;
    quiet("post_reset", 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
